// File: rtl/bus_map_pkg.sv
// Shared types and default memory map for the Riley0 bus decoder.
// Region and FSM enums, wait-state counter width, default map constants.
package bus_map_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_ROM,
    REGION_NONE
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int WS_W = 3;

  localparam logic [15:0] DEF_IO_BASE  = 16'hD000;
  localparam logic [15:0] DEF_IO_LAST  = 16'hDFFF;
  localparam logic [15:0] DEF_ROM_BASE = 16'hE000;

  localparam int DEF_IO_DEVS      = 4;
  localparam int DEF_IO_DEV_SHIFT = 8;
  localparam int DEF_RAM_WS       = 0;
  localparam int DEF_IO_WS        = 2;
  localparam int DEF_ROM_WS       = 1;

endpackage

// File: rtl/addr_region_decode.sv
// Combinational address-to-region decode for the Riley0 bus.
// Priority IO > ROM > RAM; I/O slots past IO_DEVS are unmapped.
module addr_region_decode
  import bus_map_pkg::*;
#(
  parameter int              ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] IO_BASE    = DEF_IO_BASE,
  parameter logic [ADDR_W-1:0] IO_LAST    = DEF_IO_LAST,
  parameter logic [ADDR_W-1:0] ROM_BASE   = DEF_ROM_BASE,
  parameter int              IO_DEVS      = DEF_IO_DEVS,
  parameter int              IO_DEV_SHIFT = DEF_IO_DEV_SHIFT
) (
  input  logic [ADDR_W-1:0] address,
  output region_t           region,
  output logic [2:0]        io_idx,
  output logic              unmapped
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] slot;

  assign offset = address - IO_BASE;
  assign slot   = offset >> IO_DEV_SHIFT;

  always_comb begin
    region   = REGION_RAM;
    unmapped = 1'b0;
    io_idx   = slot[2:0];
    if (address >= IO_BASE && address <= IO_LAST) begin
      if (slot >= ADDR_W'(IO_DEVS)) begin
        region   = REGION_NONE;
        unmapped = 1'b1;
      end else begin
        region   = REGION_IO;
      end
    end else if (address >= ROM_BASE) begin
      region = REGION_ROM;
    end
  end

endmodule

// File: rtl/wait_state_decoder.sv
// Riley0 memory-map decoder with latched selects and per-region
// programmable wait states signalled through rdy.
module wait_state_decoder
  import bus_map_pkg::*;
#(
  parameter int              ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] IO_BASE    = DEF_IO_BASE,
  parameter logic [ADDR_W-1:0] IO_LAST    = DEF_IO_LAST,
  parameter logic [ADDR_W-1:0] ROM_BASE   = DEF_ROM_BASE,
  parameter int              IO_DEVS      = DEF_IO_DEVS,
  parameter int              IO_DEV_SHIFT = DEF_IO_DEV_SHIFT,
  parameter int              RAM_WS       = DEF_RAM_WS,
  parameter int              IO_WS        = DEF_IO_WS,
  parameter int              ROM_WS       = DEF_ROM_WS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  address,
  input  logic               cyc,
  output logic               ram_sel_n,
  output logic               rom_sel_n,
  output logic [IO_DEVS-1:0] io_sel_n,
  output logic               rdy,
  output logic               bus_err
);

  localparam logic [IO_DEVS-1:0] IO_ONE = IO_DEVS'(1);

  region_t            region;
  logic [2:0]         io_idx;
  logic               unmapped;
  logic [WS_W-1:0]    ws;

  state_t             state, state_d;
  logic [WS_W-1:0]    cnt, cnt_d;
  logic               ram_d, rom_d, rdy_d, err_d;
  logic [IO_DEVS-1:0] io_d;

  addr_region_decode #(
    .ADDR_W       (ADDR_W),
    .IO_BASE      (IO_BASE),
    .IO_LAST      (IO_LAST),
    .ROM_BASE     (ROM_BASE),
    .IO_DEVS      (IO_DEVS),
    .IO_DEV_SHIFT (IO_DEV_SHIFT)
  ) u_dec (
    .address  (address),
    .region   (region),
    .io_idx   (io_idx),
    .unmapped (unmapped)
  );

  always_comb begin
    ws = '0;
    unique case (region)
      REGION_RAM:  ws = WS_W'(RAM_WS);
      REGION_IO:   ws = WS_W'(IO_WS);
      REGION_ROM:  ws = WS_W'(ROM_WS);
      REGION_NONE: ws = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ram_d   = ram_sel_n;
    rom_d   = rom_sel_n;
    io_d    = io_sel_n;
    rdy_d   = rdy;
    err_d   = bus_err;
    unique case (state)
      ST_IDLE: begin
        ram_d = 1'b1;
        rom_d = 1'b1;
        io_d  = '1;
        rdy_d = 1'b0;
        err_d = 1'b0;
        if (cyc) begin
          ram_d = (region != REGION_RAM);
          rom_d = (region != REGION_ROM);
          if (region == REGION_IO)
            io_d = ~(IO_ONE << io_idx);
          err_d = unmapped;
          cnt_d = ws;
          if (ws != '0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - 1'b1;
        if (cnt == WS_W'(1)) begin
          state_d = ST_DONE;
          rdy_d   = 1'b1;
        end
      end
      ST_DONE: begin
        // Address is not re-decoded here; selects stay latched
        if (!cyc) begin
          state_d = ST_IDLE;
          ram_d   = 1'b1;
          rom_d   = 1'b1;
          io_d    = '1;
          rdy_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ram_sel_n <= 1'b1;
      rom_sel_n <= 1'b1;
      io_sel_n  <= '1;
      rdy       <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ram_sel_n <= ram_d;
      rom_sel_n <= rom_d;
      io_sel_n  <= io_d;
      rdy       <= rdy_d;
      bus_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_wait_state_decoder.sv
// Self-checking bench for wait_state_decoder with default map.
// Expected cycle results are queued at stimulus time and popped on rdy.
module tb_wait_state_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'h0000;
  logic        cyc = 1'b0;
  logic        ram_sel_n, rom_sel_n, rdy, bus_err;
  logic [3:0]  io_sel_n;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0] sel;
    logic       err;
    int         lat;
  } exp_t;

  typedef struct {
    logic [5:0] first;
    logic [5:0] done;
    logic       err;
    int         lat;
    logic [5:0] rel;
    logic       rdy_rel;
  } obs_t;

  exp_t sbq[$];

  wait_state_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .cyc       (cyc),
    .ram_sel_n (ram_sel_n),
    .rom_sel_n (rom_sel_n),
    .io_sel_n  (io_sel_n),
    .rdy       (rdy),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] sel_now();
    return {ram_sel_n, rom_sel_n, io_sel_n};
  endfunction

  // Reference map: bit5 RAM, bit4 ROM, bits3:0 I/O devices
  function automatic exp_t model(input logic [15:0] a);
    exp_t m;
    int   idx;
    m.sel = 6'h3f;
    m.err = 1'b0;
    m.lat = 1;
    if (a >= 16'hD000 && a <= 16'hDFFF) begin
      idx = int'((a - 16'hD000) >> 8);
      if (idx < 4) begin
        m.sel[idx] = 1'b0;
        m.lat = 3;
      end else begin
        m.err = 1'b1;
      end
    end else if (a >= 16'hE000) begin
      m.sel[4] = 1'b0;
      m.lat = 2;
    end else begin
      m.sel[5] = 1'b0;
    end
    return m;
  endfunction

  // Entered at a negedge; returns at the negedge after release.
  task automatic run_cycle(input logic [15:0] a, output obs_t o);
    o.first = 6'h3f;
    o.lat = -1;
    address = a;
    cyc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) o.first = sel_now();
      if (rdy) begin
        o.lat = i;
        break;
      end
    end
    o.done = sel_now();
    o.err = bus_err;
    cyc = 1'b0;
    @(negedge clk);
    o.rel = sel_now();
    o.rdy_rel = rdy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({sel_now(), rdy, bus_err} !== 8'b111111_0_0) begin
      miscompares++;
      $display("FAIL reset_state got %b want %b",
               {sel_now(), rdy, bus_err}, 8'b111111_0_0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({sel_now(), rdy, bus_err} !== 8'b111111_0_0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b want %b",
               {sel_now(), rdy, bus_err}, 8'b111111_0_0);
    end
  endtask

  task automatic test_access(input string name, input logic [15:0] a);
    obs_t o;
    exp_t e;
    sbq.push_back(model(a));
    run_cycle(a, o);
    e = sbq.pop_front();
    vectors++;
    if ({o.first, o.done, o.err, o.rel, o.rdy_rel} !==
        {e.sel, e.sel, e.err, 6'h3f, 1'b0}) begin
      miscompares++;
      $display("FAIL %s @%h sel/err/rel got %b want %b", name, a,
               {o.first, o.done, o.err, o.rel, o.rdy_rel},
               {e.sel, e.sel, e.err, 6'h3f, 1'b0});
    end
    vectors++;
    if (o.lat !== e.lat) begin
      miscompares++;
      $display("FAIL %s @%h rdy_latency got %0d want %0d",
               name, a, o.lat, e.lat);
    end
  endtask

  task automatic test_addr_change();
    int lat;
    lat = -1;
    address = 16'hD000;
    cyc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) address = 16'hE000;
      vectors++;
      if (sel_now() !== 6'b11_1110) begin
        miscompares++;
        $display("FAIL addr_change clk%0d sel got %b want %b",
                 i, sel_now(), 6'b11_1110);
      end
      if (rdy) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL addr_change latency got %0d want 3", lat);
    end
    cyc = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sel_now(), rdy} !== 7'b111111_0) begin
      miscompares++;
      $display("FAIL addr_change release got %b want %b",
               {sel_now(), rdy}, 7'b111111_0);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    exp_t e1, e2;
    sbq.push_back(model(16'h0042));
    run_cycle(16'h0042, o1);
    sbq.push_back(model(16'hF00D));
    run_cycle(16'hF00D, o2);
    e1 = sbq.pop_front();
    e2 = sbq.pop_front();
    vectors++;
    if ({o1.done, o1.rel, o1.lat[3:0]} !== {e1.sel, 6'h3f, e1.lat[3:0]}) begin
      miscompares++;
      $display("FAIL b2b_ram got %b want %b",
               {o1.done, o1.rel, o1.lat[3:0]}, {e1.sel, 6'h3f, e1.lat[3:0]});
    end
    vectors++;
    if ({o2.first, o2.done, o2.rel, o2.lat[3:0]} !==
        {e2.sel, e2.sel, 6'h3f, e2.lat[3:0]}) begin
      miscompares++;
      $display("FAIL b2b_rom got %b want %b",
               {o2.first, o2.done, o2.rel, o2.lat[3:0]},
               {e2.sel, e2.sel, 6'h3f, e2.lat[3:0]});
    end
  endtask

  task automatic test_cyc_drop();
    logic [6:0] want [4];
    want[0] = 7'b11_1110_0;
    want[1] = 7'b11_1110_0;
    want[2] = 7'b11_1110_1;
    want[3] = 7'b11_1111_0;
    address = 16'hD000;
    cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) cyc = 1'b0;
      vectors++;
      if ({sel_now(), rdy} !== want[i]) begin
        miscompares++;
        $display("FAIL cyc_drop clk%0d got %b want %b",
                 i + 1, {sel_now(), rdy}, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    address = 16'hD100;
    cyc = 1'b1;
    @(negedge clk);
    vectors++;
    if ({sel_now(), rdy} !== 7'b11_1101_0) begin
      miscompares++;
      $display("FAIL rst_wait pre got %b want %b",
               {sel_now(), rdy}, 7'b11_1101_0);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({sel_now(), rdy, bus_err} !== 8'b111111_0_0) begin
      miscompares++;
      $display("FAIL rst_wait async got %b want %b",
               {sel_now(), rdy, bus_err}, 8'b111111_0_0);
    end
    cyc = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_access("after_reset", 16'h2000);
  endtask

  task automatic test_random_sweep();
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      if (i[0]) a = 16'hD000 | 16'($urandom_range(0, 16'h0FFF));
      test_access("sweep", a);
    end
  endtask

  initial begin
    test_reset();
    test_access("ram", 16'h1234);
    test_access("io2", 16'hD2A0);
    test_access("io_unmapped", 16'hDFFF);
    test_access("rom_base", 16'hE000);
    test_access("rom_top", 16'hFFFF);
    test_access("io_last_dev", 16'hD3FF);
    test_access("ram_top", 16'hCFFF);
    test_addr_change();
    test_back_to_back();
    test_cyc_drop();
    test_reset_mid_wait();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
